// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity selectors and data width.
// The receiver imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;
  localparam int   UART_DATA_W = 8;

  // Parity bit for a byte: even parity repeats the XOR, odd parity inverts it.
  function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data, input logic typ);
    return (typ == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/tx_edge_bit_counter.sv
// Counts clk edges inside one serial bit (0..P-1) and data bits inside a frame (0..7).
// Both counts sit at zero whenever the transmitter is idle.
module tx_edge_bit_counter #(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               bit_adv,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               bit_done
);

  localparam logic [PRESC_W-1:0] EDGE_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [BIT_W-1:0]   BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};

  // prescale is already clamped to at least 1 by the caller.
  assign bit_done = (edge_cnt == (prescale - EDGE_ONE));

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_done) begin
      edge_cnt <= '0;
      if (bit_adv) begin
        bit_cnt <= bit_cnt + BIT_ONE;
      end
    end else begin
      edge_cnt <= edge_cnt + EDGE_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches one byte per handshake and sends start, 8 data bits LSB-first,
// optional parity and stop, each bit lasting the latched prescale in clk cycles.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W  = UART_DATA_W,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [DATA_W-1:0]  p_data,
  input  logic               data_valid,
  input  logic               par_en,
  input  logic               par_typ,
  output logic               tx_out,
  output logic               busy
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]   BIT_ONE   = {{(BIT_W-1){1'b0}}, 1'b1};
  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  tx_state_t            r_state;
  tx_state_t            w_next_state;
  logic [DATA_W-1:0]    r_shreg;
  logic [PRESC_W-1:0]   r_presc;
  logic                 r_par_en;
  logic                 r_par_typ;
  logic                 r_tx;
  logic                 r_busy;
  logic                 w_next_tx;
  logic                 w_accept;
  logic                 w_parity;
  logic [BIT_W-1:0]     w_next_bit;
  logic [PRESC_W-1:0]   w_edge_cnt;
  logic [BIT_W-1:0]     w_bit_cnt;
  logic                 w_bit_done;
  logic                 w_unused_edge;

  assign w_accept      = (r_state == TX_IDLE) && data_valid;
  assign w_parity      = r_par_typ ? ~^r_shreg : ^r_shreg;
  assign w_unused_edge = ^w_edge_cnt;

  tx_edge_bit_counter #(
    .PRESC_W (PRESC_W),
    .BIT_W   (BIT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .enable   (r_state != TX_IDLE),
    .prescale (r_presc),
    .bit_adv  (r_state == TX_DATA),
    .edge_cnt (w_edge_cnt),
    .bit_cnt  (w_bit_cnt),
    .bit_done (w_bit_done)
  );

  // tx_out is a register, so its next value is derived from the next state and next bit index.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      TX_IDLE:   if (data_valid) w_next_state = TX_START;
      TX_START:  if (w_bit_done) w_next_state = TX_DATA;
      TX_DATA:   if (w_bit_done && (w_bit_cnt == LAST_BIT))
                   w_next_state = r_par_en ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_bit_done) w_next_state = TX_STOP;
      TX_STOP:   if (w_bit_done) w_next_state = TX_IDLE;
      default:   w_next_state = TX_IDLE;
    endcase

    w_next_bit = ((r_state == TX_DATA) && w_bit_done) ? (w_bit_cnt + BIT_ONE) : w_bit_cnt;

    w_next_tx = 1'b1;
    case (w_next_state)
      TX_START:  w_next_tx = 1'b0;
      TX_DATA:   w_next_tx = r_shreg[w_next_bit];
      TX_PARITY: w_next_tx = w_parity;
      default:   w_next_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TX_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_shreg   <= '0;
      r_presc   <= PRESC_ONE;
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_next_tx;
      r_busy  <= (w_next_state != TX_IDLE);
      if (w_accept) begin
        r_shreg   <= p_data;
        r_presc   <= (prescale == '0) ? PRESC_ONE : prescale;
        r_par_en  <= par_en;
        r_par_typ <= par_typ;
      end
    end
  end

  assign tx_out = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: each frame is predicted cycle by cycle
// from a list of serial bits, each repeated for the effective prescale.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int nCompared;
  int nMismatched;

  uart_tx_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checks len cycles of a frame from the cycle after acceptance; noise scrambles inputs meanwhile.
  task automatic expectFrame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                             input bit noise, input int ncyc, input string tag);
    logic bits [0:10];
    int   nb;
    int   ones;
    int   len;
    ones    = $countones(d);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (pen) begin
      bits[9] = ptyp ? (ones % 2 == 0) : (ones % 2 == 1);
      nb = 10;
    end
    bits[nb] = 1'b1;
    nb++;
    len = nb * p;
    if (ncyc >= 0 && ncyc < len) len = ncyc;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      nCompared++;
      if (tx_out !== bits[k/p] || busy !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL %s cycle %0d: tx_out=%b busy=%b, required tx_out=%b busy=1",
                 tag, k, tx_out, busy, bits[k/p]);
      end
      if (noise) begin
        data_valid = 1'($urandom_range(0, 1));
        p_data     = 8'($urandom);
        par_en     = 1'($urandom_range(0, 1));
        par_typ    = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    nCompared++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s idle: tx_out=%b busy=%b, required tx_out=1 busy=0", tag, tx_out, busy);
    end
  endtask

  // Presents one request; postPresc < 0 randomizes prescale after acceptance.
  task automatic startFrame(input logic [7:0] d, input logic [5:0] presc, input logic pen,
                            input logic ptyp, input int postPresc, input int ncyc, input string tag);
    int effP;
    effP = (presc == 6'd0) ? 1 : int'(presc);
    checkIdle({tag, " before"});
    p_data     = d;
    prescale   = presc;
    par_en     = pen;
    par_typ    = ptyp;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    prescale   = (postPresc < 0) ? 6'($urandom) : 6'(postPresc);
    expectFrame(d, effP, pen, ptyp, 1'b1, ncyc, tag);
    data_valid = 1'b0;
    if (ncyc < 0) checkIdle({tag, " after"});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) checkIdle("reset initial");
    rst = 1'b0;
    startFrame(8'hC3, 6'd3, 1'b1, 1'b0, -1, 10, "reset midframe");
    rst        = 1'b1;
    data_valid = 1'b0;
    repeat (3) checkIdle("reset held");
    rst = 1'b0;
  endtask

  task automatic test_basic;
    startFrame(8'hA5, 6'd4, 1'b0, 1'b0, -1, -1, "basic A5");
  endtask

  task automatic test_parity;
    startFrame(8'h07, 6'd8, 1'b1, 1'b0, -1, -1, "parity even");
    startFrame(8'h07, 6'd8, 1'b1, 1'b1, -1, -1, "parity odd");
  endtask

  task automatic test_back_to_back;
    checkIdle("b2b before");
    p_data     = 8'h55;
    prescale   = 6'd2;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    p_data = 8'hAA;
    expectFrame(8'h55, 2, 1'b0, 1'b0, 1'b0, -1, "b2b first");
    checkIdle("b2b gap");
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    expectFrame(8'hAA, 2, 1'b0, 1'b0, 1'b1, -1, "b2b second");
    data_valid = 1'b0;
    checkIdle("b2b after");
  endtask

  task automatic test_prescale_zero;
    startFrame(8'h3C, 6'd0, 1'b0, 1'b0, 5, -1, "prescale zero");
  endtask

  task automatic test_reset_in_data;
    startFrame(8'hFF, 6'd4, 1'b0, 1'b0, -1, 18, "abort FF");
    rst        = 1'b1;
    data_valid = 1'b0;
    checkIdle("abort reset");
    rst = 1'b0;
    startFrame(8'h96, 6'd3, 1'b1, 1'b1, -1, -1, "after abort");
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      startFrame(8'($urandom), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), -1, -1, "random");
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b1;
    prescale    = 6'd0;
    p_data      = 8'h00;
    data_valid  = 1'b0;
    par_en      = 1'b0;
    par_typ     = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_prescale_zero();
    test_reset_in_data();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
